// File: rtl/agu_seq2d_if.sv
// Descriptor and address-stream bundle for agu_seq2d.
// The slave modport is the sequencer; the master side is the host and the consumer.
interface agu_seq2d_if #(
  parameter int W  = 32,
  parameter int CW = 16
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [W-1:0]  cfg_base;
  logic [W-1:0]  cfg_istride;
  logic [CW-1:0] cfg_icnt_m1;
  logic [W-1:0]  cfg_ostride;
  logic [CW-1:0] cfg_ocnt_m1;
  logic          abort;
  logic [W-1:0]  addr;
  logic          addr_valid;
  logic          addr_ready;
  logic          addr_row_last;
  logic          addr_last;
  logic          busy;
  logic          done;
  logic [31:0]   perf_stall;

  modport master (
    output cfg_valid, cfg_base, cfg_istride, cfg_icnt_m1, cfg_ostride, cfg_ocnt_m1,
    output abort, addr_ready,
    input  cfg_ready, addr, addr_valid, addr_row_last, addr_last, busy, done, perf_stall
  );

  modport slave (
    input  cfg_valid, cfg_base, cfg_istride, cfg_icnt_m1, cfg_ostride, cfg_ocnt_m1,
    input  abort, addr_ready,
    output cfg_ready, addr, addr_valid, addr_row_last, addr_last, busy, done, perf_stall
  );
endinterface

// File: rtl/agu_seq2d.sv
// Two-level strided address sequencer: one descriptor in, (icnt+1)*(ocnt+1) addresses out.
// Define AGU_SEQ_PERF_EN to build the saturating stall-cycle counter on perf_stall.
module agu_seq2d #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input logic        clk,
  input logic        rst_n,
  agu_seq2d_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [W-1:0]  addr_q, row_base, istride, ostride;
  logic [CW-1:0] i_idx, o_idx, icnt, ocnt;
  logic          done_q;
  logic          row_end, job_end, beat, accept;

  assign row_end = (i_idx == icnt);
  assign job_end = row_end & (o_idx == ocnt);
  assign beat    = (state == RUN) & bus.addr_ready;
  assign accept  = (state == IDLE) & bus.cfg_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      row_base <= '0;
      istride  <= '0;
      ostride  <= '0;
      i_idx    <= '0;
      o_idx    <= '0;
      icnt     <= '0;
      ocnt     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            addr_q   <= bus.cfg_base;
            row_base <= bus.cfg_base;
            istride  <= bus.cfg_istride;
            ostride  <= bus.cfg_ostride;
            icnt     <= bus.cfg_icnt_m1;
            ocnt     <= bus.cfg_ocnt_m1;
            i_idx    <= '0;
            o_idx    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            if (!row_end) begin
              i_idx  <= i_idx + 1'b1;
              addr_q <= addr_q + istride;
            end else begin
              // Next row restarts from the row base, not from the last inner address.
              i_idx    <= '0;
              o_idx    <= o_idx + 1'b1;
              row_base <= row_base + ostride;
              addr_q   <= row_base + ostride;
            end
          end
          // abort beats a coincident final beat, so it also suppresses done.
          if (bus.abort) begin
            state <= IDLE;
          end else if (beat && job_end) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready     = (state == IDLE);
  assign bus.addr_valid    = (state == RUN);
  assign bus.busy          = (state == RUN);
  assign bus.addr_row_last = (state == RUN) & row_end;
  assign bus.addr_last     = (state == RUN) & job_end;
  assign bus.addr          = addr_q;
  assign bus.done          = done_q;

`ifdef AGU_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if ((state == RUN) && !bus.addr_ready && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_stall = perf_q;
`else
  assign bus.perf_stall = '0;
`endif
endmodule

// File: tb/tb_agu_seq2d.sv
// Self-checking bench for agu_seq2d: vector table, corner sequences and random jobs
// against an address-list model built from base + o*ostride + i*istride.
module tb_agu_seq2d;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  agu_seq2d_if #(.W(32), .CW(16)) bus();
  agu_seq2d #(.W(32), .CW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] base;
    logic [31:0] istride;
    logic [15:0] icnt;
    logic [31:0] ostride;
    logic [15:0] ocnt;
    int          exp_beats;
    logic [31:0] exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        rl;
    logic        l;
  } beat_t;

  vec_t  tbl[5];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: row-major walk, every address computed from scratch mod 2^32.
  task automatic build(input vec_t j);
    exp_q.delete();
    for (int o = 0; o <= int'(j.ocnt); o++) begin
      for (int i = 0; i <= int'(j.icnt); i++) begin
        beat_t b;
        b.addr = j.base + 32'(o) * j.ostride + 32'(i) * j.istride;
        b.rl   = (i == int'(j.icnt));
        b.l    = b.rl && (o == int'(j.ocnt));
        exp_q.push_back(b);
      end
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
  task automatic send_cfg(input vec_t j);
    chk("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_valid   = 1'b1;
    bus.cfg_base    = j.base;
    bus.cfg_istride = j.istride;
    bus.cfg_icnt_m1 = j.icnt;
    bus.cfg_ostride = j.ostride;
    bus.cfg_ocnt_m1 = j.ocnt;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("first_addr", bus.addr, j.base);
  endtask

  task automatic run(input vec_t j, input int pct, input int stall_at, input int stall_len,
                     input int abort_at, input bit tail, input bit use_tbl);
    int nb = 0, sc = 0, stalls = 0, guard = 0;
    logic [31:0] la = '0;
    bit rdy, ab, aborted = 1'b0;
    build(j);
    send_cfg(j);
    while (exp_q.size() > 0 && guard < 4000) begin
      chk("valid", bus.addr_valid, 1);
      chk("addr", bus.addr, exp_q[0].addr);
      chk("row_last", bus.addr_row_last, exp_q[0].rl);
      chk("last", bus.addr_last, exp_q[0].l);
      chk("no_done_run", bus.done, 0);
      chk("cfg_ready_run", bus.cfg_ready, 0);
      ab = 1'b0;
      if (nb == stall_at && sc < stall_len) begin
        rdy = 1'b0;
        sc++;
      end else begin
        rdy = ($urandom_range(99) < pct);
      end
      if (nb == abort_at) begin
        rdy = 1'b1;
        ab  = 1'b1;
      end
      if (!rdy) stalls++;
      bus.addr_ready = rdy;
      bus.abort      = ab;
      bus.cfg_valid  = 1'($urandom_range(1));
      bus.cfg_base   = $urandom;
      @(negedge clk);
      bus.abort     = 1'b0;
      bus.cfg_valid = 1'b0;
      if (rdy) begin
        la = exp_q[0].addr;
        void'(exp_q.pop_front());
        nb++;
      end
      if (ab) begin
        aborted = 1'b1;
        exp_q.delete();
      end
      guard++;
    end
    if (guard >= 4000) chk("timeout", guard, 0);
    bus.addr_ready = 1'b0;
    chk("end_valid", bus.addr_valid, 0);
    chk("end_busy", bus.busy, 0);
    chk("end_cfg_ready", bus.cfg_ready, 1);
    chk("done_pulse", bus.done, aborted ? 0 : 1);
    if (use_tbl && !aborted) begin
      chk("tbl_beats", nb, j.exp_beats);
      chk("tbl_last_addr", la, j.exp_last);
    end
`ifdef AGU_SEQ_PERF_EN
    chk("perf_stall", bus.perf_stall, stalls);
`else
    chk("perf_stall_off", bus.perf_stall, 0);
`endif
    if (tail) begin
      @(negedge clk);
      chk("done_clear", bus.done, 0);
    end
  endtask

  initial begin
    vec_t j;
    tbl[0] = '{32'h0000_1000, 32'd4,         16'd2, 32'h0000_0100, 16'd1, 6,  32'h0000_1108};
    tbl[1] = '{32'hFFFF_FFFC, 32'd4,         16'd0, 32'h0000_0010, 16'd0, 1,  32'hFFFF_FFFC};
    tbl[2] = '{32'hFFFF_FFF8, 32'd8,         16'd1, 32'h0000_0000, 16'd0, 2,  32'h0000_0000};
    tbl[3] = '{32'h0000_0000, 32'd1,         16'd3, 32'h0000_0010, 16'd2, 12, 32'h0000_0023};
    tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 16'd1, 32'h8000_0000, 16'd1, 4,  32'hFFFF_FFFF};

    bus.cfg_valid = 1'b0; bus.cfg_base = '0; bus.cfg_istride = '0; bus.cfg_icnt_m1 = '0;
    bus.cfg_ostride = '0; bus.cfg_ocnt_m1 = '0; bus.abort = 1'b0; bus.addr_ready = 1'b0;

    #12;
    chk("rst_addr", bus.addr, 0);
    chk("rst_valid", bus.addr_valid, 0);
    chk("rst_row_last", bus.addr_row_last, 0);
    chk("rst_last", bus.addr_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_perf", bus.perf_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cfg_ready_after_rst", bus.cfg_ready, 1);

    for (int k = 0; k < 5; k++) run(tbl[k], 100, -1, 0, -1, 1, 1);

    // Three-cycle stall on beat 2: address must hold 0x1004.
    run(tbl[0], 100, 1, 3, -1, 1, 1);
    // Back-to-back jobs: second descriptor offered in the done cycle.
    run(tbl[0], 100, -1, 0, -1, 0, 1);
    run(tbl[4], 100, -1, 0, -1, 1, 1);
    // Abort on beat 2, then a fresh job in the very next cycle.
    run(tbl[0], 100, -1, 0, 1, 0, 0);
    run(tbl[3], 100, -1, 0, -1, 1, 1);
    // Abort coinciding with the only (final) beat: no done.
    run(tbl[1], 100, -1, 0, 0, 1, 0);
    // Abort held in IDLE must not block acceptance.
    bus.abort = 1'b1;
    run(tbl[2], 100, -1, 0, -1, 1, 1);

    // Asynchronous reset mid-job.
    build(tbl[3]);
    send_cfg(tbl[3]);
    bus.addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", bus.addr, 0);
    chk("mid_rst_valid", bus.addr_valid, 0);
    chk("mid_rst_row_last", bus.addr_row_last, 0);
    chk("mid_rst_last", bus.addr_last, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_perf", bus.perf_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.addr_ready = 1'b0;
    @(negedge clk);
    chk("cfg_ready_rel", bus.cfg_ready, 1);
    chk("valid_rel", bus.addr_valid, 0);
    run(tbl[0], 100, -1, 0, -1, 1, 1);

    for (int r = 0; r < 25; r++) begin
      j.base      = $urandom;
      j.istride   = $urandom;
      j.icnt      = 16'($urandom_range(5));
      j.ostride   = $urandom;
      j.ocnt      = 16'($urandom_range(4));
      j.exp_beats = 0;
      j.exp_last  = '0;
      run(j, 70, -1, 0, (r % 5 == 4) ? int'($urandom_range(3)) : -1, r[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
